// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared size encodings, FSM state type and word geometry for the load/store unit
package mem_access_pkg;
   localparam int WORD_BYTES = 4;
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: little-endian lane extraction for loads and lane merge for sub-word stores
module mem_lane_unit
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wbuf,
   input  logic [31:0] wdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sgn,
   output logic [31:0] rdata,
   output logic [31:0] merged
);
   function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] o,
                                                input logic [1:0] s, input logic sx);
      logic [31:0] lane;
      lane = w >> {o, 3'b000};
      return s == SIZE_B ? {{24{sx & lane[7]}}, lane[7:0]} :
             s == SIZE_H ? {{16{sx & lane[15]}}, lane[15:0]} : w;
   endfunction
   function automatic logic [31:0] store_merge(input logic [31:0] b, input logic [31:0] d,
                                               input logic [1:0] o, input logic [1:0] s);
      logic [31:0] mask;
      mask = s == SIZE_B ? 32'h0000_00FF << {o, 3'b000} :
             s == SIZE_H ? 32'h0000_FFFF << {o, 3'b000} : 32'hFFFF_FFFF;
      return (b & ~mask) | ((d << {o, 3'b000}) & mask);
   endfunction
   always_comb begin
      rdata  = load_extract(word, off, size, sgn);
      merged = store_merge(wbuf, wdata, off, size);
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store sequencer with read-modify-write for sub-word stores
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);
   state_t state, state_n;
   logic we_q, sgn_q, acc, err;
   logic [1:0] size_q, off_q;
   logic [31:0] wdata_q, word_buf, lane_word, ld_data, st_data;
   assign req_ready = state == IDLE && rst;
   assign acc = req_valid && req_ready;
   assign err = req_size == 2'd3 || (req_size == SIZE_H && req_addr[0]) ||
                (req_size == SIZE_W && req_addr[1:0] != 2'b00) ||
                req_addr >= 32'(MEM_WORDS * WORD_BYTES);
   // In READ the fresh memory word is used directly so the merged store word is ready for WRITE
   assign lane_word = state == READ ? mem_rdata : word_buf;
   mem_lane_unit u_lane (
      .word(lane_word), .wbuf(lane_word), .wdata(wdata_q), .off(off_q),
      .size(size_q), .sgn(sgn_q), .rdata(ld_data), .merged(st_data)
   );
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = !acc ? IDLE : err ? RESP :
                            (req_we && req_size == SIZE_W) ? WRITE : READ;
         READ:    state_n = we_q ? WRITE : RESP;
         WRITE:   state_n = RESP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         sgn_q      <= 1'b0;
         size_q     <= '0;
         off_q      <= '0;
         wdata_q    <= '0;
         word_buf   <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state      <= state_n;
         mem_we     <= state_n == WRITE;
         resp_valid <= state_n == RESP;
         if (acc) begin
            we_q       <= req_we;
            sgn_q      <= req_signed;
            size_q     <= req_size;
            off_q      <= req_addr[1:0];
            wdata_q    <= req_wdata;
            resp_err   <= err;
            resp_rdata <= '0;
            if (!err) mem_addr <= {req_addr[31:2], 2'b00};
            if (!err && req_we && req_size == SIZE_W) mem_wdata <= req_wdata;
         end
         if (state == READ) begin
            word_buf <= mem_rdata;
            if (we_q) mem_wdata <= st_data;
            else resp_rdata <= ld_data;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of loads, stores, RMW, errors, handshake and reset against a behavioural memory
module tb_mem_access_unit;
   logic clk = 1'b0, rst = 1'b0;
   logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
   logic [1:0] req_size = 2'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic req_ready, resp_valid, resp_err, mem_we;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] mem [0:1023];
   int passed = 0, total = 0;
   always #5 clk = ~clk;
   mem_access_unit #(.MEM_WORDS(1024)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );
   assign mem_rdata = mem[mem_addr[11:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
   initial for (int i = 0; i < 1024; i++) mem[i] = '0;

   task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_wdata = 32'h5A5A_5A5A; req_addr = 32'hFFFF_FFFC;
   endtask

   task automatic wait_resp(output int lat, output int nwe, output logic [31:0] wa, output logic [31:0] wd);
      lat = 0; nwe = 0; wa = '0; wd = '0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (mem_we) begin nwe++; wa = mem_addr; wd = mem_wdata; end
         if (resp_valid) begin lat = i; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (req_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", req_ready); else passed++;
      total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", resp_valid); else passed++;
      total++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err got %b exp 0", resp_err); else passed++;
      total++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", resp_rdata); else passed++;
      total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b exp 0", mem_we); else passed++;
      total++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL reset_mem_bus got %h/%h exp 0/0", mem_addr, mem_wdata); else passed++;
      rst = 1'b1;
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", req_ready); else passed++;
   endtask

   task automatic test_word;
      int lat, nwe;
      logic [31:0] wa, wd;
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
      wait_resp(lat, nwe, wa, wd);
      total++; if (lat !== 2) $display("FAIL sw_latency got %0d exp 2", lat); else passed++;
      total++; if (nwe !== 1) $display("FAIL sw_we_cycles got %0d exp 1", nwe); else passed++;
      total++; if (wa !== 32'h10 || wd !== 32'hDEAD_BEEF) $display("FAIL sw_bus got %h/%h exp 00000010/deadbeef", wa, wd); else passed++;
      total++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0) $display("FAIL sw_resp got err %b rdata %h exp 0/0", resp_err, resp_rdata); else passed++;
      issue(1'b0, 2'd2, 1'b1, 32'h10, 32'h0);
      wait_resp(lat, nwe, wa, wd);
      total++; if (lat !== 2) $display("FAIL lw_latency got %0d exp 2", lat); else passed++;
      total++; if (resp_rdata !== 32'hDEAD_BEEF) $display("FAIL lw_rdata got %h exp deadbeef", resp_rdata); else passed++;
      total++; if (nwe !== 0) $display("FAIL lw_no_write got %0d exp 0", nwe); else passed++;
   endtask

   task automatic test_subword_store;
      int lat, nwe;
      logic [31:0] wa, wd;
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
      wait_resp(lat, nwe, wa, wd);
      issue(1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFF_FFAB);
      wait_resp(lat, nwe, wa, wd);
      total++; if (lat !== 3) $display("FAIL sb_latency got %0d exp 3", lat); else passed++;
      total++; if (nwe !== 1 || wd !== 32'h11AB_3344) $display("FAIL sb_merge got %0d writes data %h exp 1/11ab3344", nwe, wd); else passed++;
      total++; if (mem[4] !== 32'h11AB_3344) $display("FAIL sb_mem got %h exp 11ab3344", mem[4]); else passed++;
      issue(1'b1, 2'd1, 1'b0, 32'h12, 32'hCAFE_1234);
      wait_resp(lat, nwe, wa, wd);
      total++; if (lat !== 3 || wd !== 32'h1234_3344) $display("FAIL sh_merge got lat %0d data %h exp 3/12343344", lat, wd); else passed++;
   endtask

   task automatic test_loads;
      int lat, nwe;
      logic [31:0] wa, wd;
      logic [1:0]  sz [5]  = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
      logic        sg [5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] ad [5]  = '{32'h22, 32'h22, 32'h22, 32'h20, 32'h20};
      logic [31:0] ex [5]  = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_0001, 32'h0000_7F01};
      issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF_7F01);
      wait_resp(lat, nwe, wa, wd);
      for (int i = 0; i < 5; i++) begin
         issue(1'b0, sz[i], sg[i], ad[i], 32'h0);
         wait_resp(lat, nwe, wa, wd);
         total++;
         if (lat !== 2 || resp_rdata !== ex[i] || resp_err !== 1'b0)
            $display("FAIL load_%0d got lat %0d rdata %h err %b exp 2/%h/0", i, lat, resp_rdata, resp_err, ex[i]);
         else passed++;
      end
   endtask

   task automatic test_errors;
      int lat, nwe;
      logic [31:0] wa, wd;
      logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [1:0]  sz [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
      logic [31:0] ad [4] = '{32'h13, 32'h12, 32'h10, 32'h1000};
      for (int i = 0; i < 4; i++) begin
         issue(we[i], sz[i], 1'b1, ad[i], 32'hFFFF_FFFF);
         wait_resp(lat, nwe, wa, wd);
         total++; if (lat !== 1) $display("FAIL err_%0d_latency got %0d exp 1", i, lat); else passed++;
         total++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) $display("FAIL err_%0d_resp got err %b rdata %h exp 1/0", i, resp_err, resp_rdata); else passed++;
         total++; if (nwe !== 0) $display("FAIL err_%0d_write got %0d exp 0", i, nwe); else passed++;
      end
      total++; if (mem[4] !== 32'h1234_3344) $display("FAIL err_mem_intact got %h exp 12343344", mem[4]); else passed++;
   endtask

   task automatic test_back_to_back;
      int acc = 0, rv = 0;
      @(negedge clk);
      req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h30; req_wdata = 32'h55;
      req_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++; if (req_ready !== (i % 4 == 0)) $display("FAIL hs_ready_%0d got %b exp %b", i, req_ready, i % 4 == 0); else passed++;
         if (req_ready) acc++;
         if (resp_valid) rv++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      total++; if (acc !== 2 || rv !== 2) $display("FAIL hs_counts got acc %0d resp %0d exp 2/2", acc, rv); else passed++;
      @(negedge clk);
      total++; if (mem[12] !== 32'h55) $display("FAIL hs_mem got %h exp 00000055", mem[12]); else passed++;
   endtask

   task automatic test_reset_mid;
      int lat, nwe, bad = 0;
      logic [31:0] wa, wd;
      issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hAAAA_AAAA);
      wait_resp(lat, nwe, wa, wd);
      issue(1'b1, 2'd0, 1'b0, 32'h41, 32'h77);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (mem_we || resp_valid) bad++;
      end
      total++; if (bad !== 0) $display("FAIL rstmid_activity got %0d exp 0", bad); else passed++;
      total++; if (mem[16] !== 32'hAAAA_AAAA) $display("FAIL rstmid_mem got %h exp aaaaaaaa", mem[16]); else passed++;
      total++; if ({resp_err, resp_rdata, mem_addr, mem_wdata} !== 97'h0) $display("FAIL rstmid_outputs got %b/%h/%h/%h exp 0", resp_err, resp_rdata, mem_addr, mem_wdata); else passed++;
      rst = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready got %b exp 1", req_ready); else passed++;
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword_store();
      test_loads();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
